// File: rtl/plane_walk.sv
// plane_walk: latches one plane equation, seeds start = x0*ddx + y0*ddy + c, then walks the tile in raster order by incremental adds.
// Optional macro PLANE_WALK_CLAMP_EN saturates pix_value to [0, 255<<FRAC_BITS]; the accumulators always wrap.
module plane_walk #(
  parameter int FRAC_BITS = 8,
  parameter int TILE_W    = 32,
  parameter int TILE_H    = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      coef_valid,
  output logic                      coef_ready,
  input  logic [31:0]               ddx,
  input  logic [31:0]               ddy,
  input  logic [31:0]               c,
  input  logic [31:0]               x0,
  input  logic [31:0]               y0,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [$clog2(TILE_W)-1:0] pix_x,
  output logic [$clog2(TILE_H)-1:0] pix_y,
  output logic [31:0]               pix_value,
  output logic                      pix_last,
  output logic                      busy
);

  localparam int XW = $clog2(TILE_W);
  localparam int YW = $clog2(TILE_H);
  localparam logic [XW-1:0] X_MAX = XW'(TILE_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(TILE_H - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);
  // Bias added to negative products so the shift rounds toward zero like a signed divide.
  localparam logic signed [63:0] RND = (64'sd1 <<< FRAC_BITS) - 64'sd1;

  typedef enum logic [1:0] {IDLE, SEED, WALK} state_t;

  state_t state, state_nx;

  logic [31:0] ddx_q, ddy_q, c_q, x0_q, y0_q;
  logic [31:0] row_acc, pix_acc;
  logic signed [63:0] prod_x, prod_y;
  logic [31:0] start;
  logic x_end, y_end;

  function automatic logic signed [63:0] div_frac(input logic signed [63:0] p);
    return (p + (p[63] ? RND : 64'sd0)) >>> FRAC_BITS;
  endfunction

  assign prod_x = $signed({{32{x0_q[31]}}, x0_q}) * $signed({{32{ddx_q[31]}}, ddx_q});
  assign prod_y = $signed({{32{y0_q[31]}}, y0_q}) * $signed({{32{ddy_q[31]}}, ddy_q});
  assign start  = 32'(div_frac(prod_x)) + 32'(div_frac(prod_y)) + c_q;

  assign x_end = (pix_x == X_MAX);
  assign y_end = (pix_y == Y_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (coef_valid) state_nx = SEED;
      SEED:    state_nx = WALK;
      WALK:    if (pix_ready && x_end && y_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ddx_q   <= '0;
      ddy_q   <= '0;
      c_q     <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      row_acc <= '0;
      pix_acc <= '0;
      pix_x   <= '0;
      pix_y   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (coef_valid) begin
            ddx_q <= ddx;
            ddy_q <= ddy;
            c_q   <= c;
            x0_q  <= x0;
            y0_q  <= y0;
          end
        end
        SEED: begin
          row_acc <= start;
          pix_acc <= start;
          pix_x   <= '0;
          pix_y   <= '0;
        end
        WALK: begin
          if (pix_ready) begin
            if (!x_end) begin
              pix_x   <= pix_x + X_ONE;
              pix_acc <= pix_acc + ddx_q;
            end else if (!y_end) begin
              pix_x   <= '0;
              pix_y   <= pix_y + Y_ONE;
              row_acc <= row_acc + ddy_q;
              pix_acc <= row_acc + ddy_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    coef_ready = (state == IDLE);
    busy       = (state != IDLE);
    pix_valid  = (state == WALK);
    pix_last   = (state == WALK) && x_end && y_end;
  end

`ifdef PLANE_WALK_CLAMP_EN
  localparam logic signed [31:0] VMAX = 32'sd255 <<< FRAC_BITS;
  always_comb begin
    if ($signed(pix_acc) < 32'sd0)     pix_value = '0;
    else if ($signed(pix_acc) > VMAX)  pix_value = VMAX;
    else                               pix_value = pix_acc;
  end
`else
  assign pix_value = pix_acc;
`endif

endmodule

// File: tb/tb_plane_walk.sv
// tb_plane_walk: directed tiles (ramp, stall, offset seed, truncation, mid-walk reset, clamp) against hand-computed values
// and the closed form start + i*ddx + j*ddy.
module tb_plane_walk;

  logic        clock;
  logic        reset_n;
  logic        coef_valid;
  logic        coef_ready;
  logic [31:0] ddx, ddy, c, x0, y0;
  logic        pix_valid;
  logic        pix_ready;
  logic [4:0]  pix_x;
  logic [4:0]  pix_y;
  logic [31:0] pix_value;
  logic        pix_last;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  int          ncyc;
  int          errs;
  int          last_cnt;
  logic [31:0] cap [0:6];
  logic [31:0] cap01;
  logic [31:0] capend;

  plane_walk #(.FRAC_BITS(8), .TILE_W(32), .TILE_H(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .ddx(ddx), .ddy(ddy), .c(c), .x0(x0), .y0(y0),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_value(pix_value),
    .pix_last(pix_last), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] st, input logic [31:0] dx,
                                        input logic [31:0] dy, input int i, input int j);
    logic [31:0] v;
    v = st + 32'(i) * dx + 32'(j) * dy;
`ifdef PLANE_WALK_CLAMP_EN
    if ($signed(v) < 0) v = 32'h0;
    else if ($signed(v) > 32'sh0000FF00) v = 32'h0000FF00;
`endif
    return v;
  endfunction

  task automatic run_tile(input string tag, input logic [31:0] t_ddx, input logic [31:0] t_ddy,
                          input logic [31:0] t_c, input logic [31:0] t_x0, input logic [31:0] t_y0,
                          input logic [31:0] st, input int stall_idx, input int abort_idx);
    int idx, i, j, stall_left;
    logic [31:0] ev;
    logic acc, aborted;
    idx = 0; errs = 0; last_cnt = 0; stall_left = 3; aborted = 1'b0;
    @(negedge clock);
    ddx = t_ddx; ddy = t_ddy; c = t_c; x0 = t_x0; y0 = t_y0;
    coef_valid = 1'b1;
    pix_ready  = 1'b1;
    check({tag, "_coef_ready_idle"}, 32'(coef_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    coef_valid = 1'b0;
    ncyc = 1;
    check({tag, "_seed_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_seed_coef_ready"}, 32'(coef_ready), 32'd0);
    check({tag, "_seed_busy"}, 32'(busy), 32'd1);
    @(negedge clock);
    ncyc = 2;
    while (idx < 1024 && ncyc < 3000) begin
      i = idx % 32;
      j = idx / 32;
      ev = model(st, t_ddx, t_ddy, i, j);
      if (!pix_valid || pix_x !== 5'(i) || pix_y !== 5'(j) || pix_value !== ev ||
          pix_last !== (idx == 1023) || coef_ready !== 1'b0)
        errs++;
      if (j == 0 && i < 7) cap[i] = pix_value;
      if (idx == 32)   cap01  = pix_value;
      if (idx == 1023) capend = pix_value;
      if (idx == abort_idx) begin
        reset_n = 1'b0;
        #1;
        check({tag, "_abort_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_abort_busy"}, 32'(busy), 32'd0);
        check({tag, "_abort_coef_ready"}, 32'(coef_ready), 32'd1);
        check({tag, "_abort_value"}, pix_value, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (idx == stall_idx && stall_left > 0) begin
        pix_ready = 1'b0;
        stall_left--;
      end else begin
        pix_ready = 1'b1;
      end
      acc = pix_valid && pix_ready;
      if (acc && pix_last) last_cnt++;
      @(posedge clock);
      @(negedge clock);
      ncyc++;
      if (acc) idx++;
    end
    pix_ready = 1'b1;
    check({tag, "_pix_errs"}, 32'(errs), 32'd0);
    if (!aborted) begin
      check({tag, "_pix_count"}, 32'(idx), 32'd1024);
      check({tag, "_last_count"}, 32'(last_cnt), 32'd1);
      check({tag, "_end_valid"}, 32'(pix_valid), 32'd0);
      check({tag, "_end_coef_ready"}, 32'(coef_ready), 32'd1);
      check({tag, "_end_busy"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0; coef_valid = 1'b0; pix_ready = 1'b1;
    ddx = '0; ddy = '0; c = '0; x0 = '0; y0 = '0;
    #12;
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_coef_ready", 32'(coef_ready), 32'd1);
    check("rst_value", pix_value, 32'd0);
    check("rst_x", 32'(pix_x), 32'd0);
    check("rst_y", 32'(pix_y), 32'd0);
    check("rst_last", 32'(pix_last), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_tile("ramp", 32'h100, 32'h2000, 32'h0, 32'h0, 32'h0, 32'h0, -1, -1);
    check("ramp_cycles", 32'(ncyc), 32'd1026);
    check("ramp_p10", cap[1], 32'h100);
    check("ramp_p01", cap01, 32'h2000);
    check("ramp_p3131", capend, 32'h3FF00);

    run_tile("stall", 32'h100, 32'h2000, 32'h0, 32'h0, 32'h0, 32'h0, 5, -1);
    check("stall_cycles", 32'(ncyc), 32'd1029);
    check("stall_p50", cap[5], 32'h500);
    check("stall_p60", cap[6], 32'h600);

    run_tile("offset", 32'h80, 32'hFFFFFFC0, 32'h1000, 32'h0A00, 32'h0400, 32'h1400, -1, -1);
    check("offset_p00", cap[0], 32'h1400);
    check("offset_p10", cap[1], 32'h1480);
    check("offset_p01", cap01, 32'h13C0);

    run_tile("trunc", 32'hFFFFFFFD, 32'h0, 32'h0, 32'h0180, 32'h0, 32'hFFFFFFFC, -1, -1);
    check("trunc_p00", cap[0], 32'hFFFFFFFC);
    check("trunc_p10", cap[1], 32'hFFFFFFF9);

    run_tile("abort", 32'h100, 32'h2000, 32'h0, 32'h0, 32'h0, 32'h0, -1, 106);
    run_tile("after", 32'h80, 32'hFFFFFFC0, 32'h1000, 32'h0A00, 32'h0400, 32'h1400, -1, -1);
    check("after_p00", cap[0], 32'h1400);
    check("after_p10", cap[1], 32'h1480);

    run_tile("clamp", 32'h4000, 32'h0, 32'hFFFFFF00, 32'h0, 32'h0, 32'hFFFFFF00, -1, -1);
`ifdef PLANE_WALK_CLAMP_EN
    check("clamp_p0", cap[0], 32'h0);
    check("clamp_p1", cap[1], 32'h3F00);
    check("clamp_p2", cap[2], 32'h7F00);
    check("clamp_p3", cap[3], 32'hBF00);
    check("clamp_p4", cap[4], 32'hFF00);
    check("clamp_p5", cap[5], 32'hFF00);
`else
    check("noclamp_p0", cap[0], 32'hFFFFFF00);
    check("noclamp_p1", cap[1], 32'h3F00);
    check("noclamp_p5", cap[5], 32'h13F00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plane_walk.md
Name: plane_walk

Overview:
- Consumer end of the attribute plane-equation interface: accepts one set of plane coefficients (ddx, ddy, c) per triangle/tile pass.
- Walks a TILE_W x TILE_H pixel tile in raster order and emits one interpolated attribute value per pixel over a valid/ready stream.
- Uses incremental adds instead of per-pixel multiplies. Sits between triangle setup and the per-pixel shading/blend pipeline in the PVR tile core.

Parameters:
- FRAC_BITS, 8, fractional bits of x0/y0/ddx/ddy/c/pix_value (fixed-point format of the plane equation).
- TILE_W, 32, tile width in pixels (power of two).
- TILE_H, 32, tile height in pixels (power of two).

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- coef_valid  in  1  coefficient set offered.
- coef_ready  out  1  block can accept a coefficient set (high only in IDLE).
- ddx  in  32  signed d(attr)/dx, FRAC_BITS fixed.
- ddy  in  32  signed d(attr)/dy, FRAC_BITS fixed.
- c  in  32  signed plane constant, FRAC_BITS fixed.
- x0  in  32  signed tile origin x, FRAC_BITS fixed.
- y0  in  32  signed tile origin y, FRAC_BITS fixed.
- pix_valid  out  1  pixel output valid.
- pix_ready  in  1  downstream accepts pixel.
- pix_x  out  $clog2(TILE_W)  pixel column within tile.
- pix_y  out  $clog2(TILE_H)  pixel row within tile.
- pix_value  out  32  signed interpolated attribute, FRAC_BITS fixed.
- pix_last  out  1  marks pixel (TILE_W-1, TILE_H-1).
- busy  out  1  high in SEED or WALK.

Behaviour:
- Reset (async, reset_n=0): state=IDLE. pix_valid, pix_x, pix_y, pix_value, pix_last, busy = 0. coef_ready = 1, since it is combinational from state==IDLE. All latched coefficients are cleared to 0. Reset mid-walk abandons the tile immediately; no further pixels are emitted.
- States:
  - IDLE: coef_ready=1. On coef_valid&coef_ready, latch ddx/ddy/c/x0/y0 and go to SEED.
  - SEED: one cycle. Compute start = (x0*ddx)/2^FRAC_BITS + (y0*ddy)/2^FRAC_BITS + c.
    - Products are formed at 64 bits; division truncates toward zero (signed divide semantics, not arithmetic shift); the result is truncated to 32 bits.
    - Load row_acc = start and pix_acc = start; pix_x = pix_y = 0; assert pix_valid; go to WALK.
  - WALK: pix_value = pix_acc. On pix_valid&pix_ready:
    - if not last column: pix_x++, pix_acc += ddx.
    - else if not last row: pix_x=0, pix_y++, row_acc += ddy, pix_acc = row_acc + ddy.
    - else (pix_last): drop pix_valid, go to IDLE.
- Exact result: pixel (i,j) = start + i*ddx + j*ddy, mod 2^32 (wrap, no saturation).
- Latency: coef accepted at cycle N, first pix_valid at N+2. Throughput is 1 pixel/clock with pix_ready held high. A full tile takes TILE_W*TILE_H+2 cycles from acceptance to coef_ready.
- Backpressure: while pix_valid & !pix_ready, pix_x/pix_y/pix_value/pix_last are held stable and pix_valid is never withdrawn.
- pix_last is 1 only at (TILE_W-1, TILE_H-1).
- coef_ready is 0 in SEED/WALK. coef_valid during a walk is ignored and must be held by the source.
- The final-pixel handshake cycle returns to IDLE. coef_ready=1 the next cycle; there is no back-to-back overlap.
- busy = (state != IDLE).

Optional Feature:
- Macro: PLANE_WALK_CLAMP_EN.
- Defined: pix_value is saturated to [0, 255<<FRAC_BITS]; internal accumulators remain unclamped and wrapping.
- Undefined: pix_value is the raw accumulator; there is no clamp logic.

Test Plan:
- Ramp: ddx=0x100, ddy=0x2000, c=0, x0=y0=0, pix_ready=1 -> 1024 pixels; pixel (i,j)=256*i+8192*j; pixel (31,31)=0x3FF00 with pix_last=1; first pix_valid 2 cycles after coef handshake; coef_ready high the cycle after last.
- Offset seed: x0=0x0A00, y0=0x0400, ddx=0x80, ddy=-0x40, c=0x1000 -> pixel (0,0)=0x1400, (1,0)=0x1480, (0,1)=0x13C0.
- Truncation: x0=0x0180, y0=0, ddx=-3, ddy=0, c=0 -> pixel (0,0)=0xFFFFFFFC (-4.5 truncated toward zero to -4, not -5).
- Backpressure: ramp test, drop pix_ready for 3 cycles at pixel (5,0) -> pix_value held at 0x500, pix_valid stays 1; the next accepted pixel is (6,0)=0x600; total pixel count is still 1024.
- Reset mid-walk: assert reset_n=0 at pixel (10,3) -> pix_valid=0, busy=0, coef_ready=1 asynchronously. A new coef set after release starts at (0,0) with new values.
- Clamp (PLANE_WALK_CLAMP_EN): ddx=0x4000, ddy=0, c=-0x100 -> pixels 0..5 = 0x0, 0x3F00, 0x7F00, 0xBF00, 0xFF00, 0xFF00. Without the macro, pixel 0 = 0xFFFFFF00 and pixel 5 = 0x13F00.
